// File: rtl/spi_blk_tx.sv
// spi_blk_tx: SPI write-block sequencer -- start token, BLK_BYTES data bytes, then the CRC16 tail.
// Optional: define SPI_BLK_TX_UNDERRUN_EN to send 0xFF on a missing byte instead of stalling.
module spi_blk_tx #(
    parameter int BLK_BYTES = 512,
    parameter int CNT_W     = 10
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       bit_en_i,
    input  logic       start_i,
    input  logic       multi_blk_i,
    input  logic [7:0] byte_data_i,
    input  logic       byte_valid_i,
    output logic       byte_ready_o,
    input  logic       crc_dout_i,
    output logic       crc_din_o,
    output logic       crc_gen_en_o,
    output logic       crc_out_en_o,
    output logic       crc_ld_start_o,
    output logic       crc_ld_multi_o,
    output logic       sdo_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       underrun_o
);
    typedef enum logic [1:0] {IDLE, TOKEN, DATA, CRC} state_e;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLK_BYTES - 1);

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             multi_q, multi_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             fetch, stall;
    logic [7:0]       cur_byte;

    // First strobe of a data byte: the bit comes straight from the input, not the shifter.
    assign fetch = (state_q == DATA) && (bit_cnt_q == 4'd0);

`ifdef SPI_BLK_TX_UNDERRUN_EN
    logic underrun_q, underrun_d;

    assign stall      = 1'b0;
    assign cur_byte   = fetch ? (byte_valid_i ? byte_data_i : 8'hFF) : shift_q;
    assign underrun_o = underrun_q;

    always_comb begin
        underrun_d = underrun_q;
        if (state_q == IDLE && start_i)
            underrun_d = 1'b0;
        else if (fetch && bit_en_i && !byte_valid_i)
            underrun_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) underrun_q <= 1'b0;
        else          underrun_q <= underrun_d;
    end
`else
    assign stall      = fetch && !byte_valid_i;
    assign cur_byte   = fetch ? byte_data_i : shift_q;
    assign underrun_o = 1'b0;
`endif

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        multi_d        = multi_q;
        last_d         = last_q;
        done_d         = 1'b0;
        byte_ready_o   = 1'b0;
        crc_din_o      = 1'b0;
        crc_gen_en_o   = 1'b0;
        crc_out_en_o   = 1'b0;
        crc_ld_start_o = 1'b0;
        crc_ld_multi_o = 1'b0;
        sdo_o          = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = TOKEN;
                    multi_d    = multi_blk_i;
                    shift_d    = multi_blk_i ? 8'hFC : 8'hFE;
                    bit_cnt_d  = 4'd0;
                    byte_cnt_d = '0;
                end
            end
            TOKEN: begin
                sdo_o = shift_q[7];
                if (bit_en_i) begin
                    last_d  = shift_q[7];
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bit_cnt_q == 4'd7) begin
                        crc_ld_multi_o = multi_q;
                        crc_ld_start_o = !multi_q;
                        bit_cnt_d      = 4'd0;
                        state_d        = DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                // While stalled the line keeps the previous bit.
                sdo_o = stall ? last_q : cur_byte[7];
                if (bit_en_i && !stall) begin
                    crc_din_o    = cur_byte[7];
                    crc_gen_en_o = 1'b1;
                    byte_ready_o = fetch && byte_valid_i;
                    last_d       = cur_byte[7];
                    shift_d      = {cur_byte[6:0], 1'b0};
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d = '0;
                            state_d    = CRC;
                        end else begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            CRC: begin
                sdo_o = crc_dout_i;
                if (bit_en_i) begin
                    crc_out_en_o = 1'b1;
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = 4'd0;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 4'd0;
            byte_cnt_q <= '0;
            multi_q    <= 1'b0;
            last_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            multi_q    <= multi_d;
            last_q     <= last_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_blk_tx.sv
// Bench for spi_blk_tx: 4-byte blocks, bit_en every 2nd clk, a CRC16 stand-in downstream,
// and a bit-position reference model checked every clock.
`timescale 1ns/1ps
module tb_spi_blk_tx;
    localparam int BLK   = 4;
    localparam int DBITS = 8 * BLK;
    localparam int NBITS = 24 + DBITS;
    // CRC16-CCITT (poly 0x1021, zero init) of the 0xFE token; the multi seed is given directly.
    localparam logic [15:0] SEED_S = 16'h0ED1;
    localparam logic [15:0] SEED_M = 16'h2E93;

    logic clk = 1'b0, rst_n = 1'b0, bit_en = 1'b0, start = 1'b0, multi_blk = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic byte_valid = 1'b0;
    logic byte_ready, crc_dout, crc_din, crc_gen_en, crc_out_en, crc_ld_start, crc_ld_multi;
    logic sdo, busy, done, underrun;

    spi_blk_tx #(.BLK_BYTES(BLK), .CNT_W(3)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .bit_en_i(bit_en), .start_i(start),
        .multi_blk_i(multi_blk), .byte_data_i(byte_data), .byte_valid_i(byte_valid),
        .byte_ready_o(byte_ready), .crc_dout_i(crc_dout), .crc_din_o(crc_din),
        .crc_gen_en_o(crc_gen_en), .crc_out_en_o(crc_out_en), .crc_ld_start_o(crc_ld_start),
        .crc_ld_multi_o(crc_ld_multi), .sdo_o(sdo), .busy_o(busy), .done_o(done),
        .underrun_o(underrun)
    );

    always #5 clk = ~clk;

    int nerr = 0, nchk = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
        crc_bit = (c[15] ^ b) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    endfunction

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) r = crc_bit(r, b[i]);
        return r;
    endfunction

    // Downstream spi_crc16 stand-in.
    logic [15:0] crc_reg;
    assign crc_dout = crc_reg[15];
    always @(posedge clk) begin
        if (!rst_n)            crc_reg <= 16'h0000;
        else if (crc_ld_start) crc_reg <= SEED_S;
        else if (crc_ld_multi) crc_reg <= SEED_M;
        else if (crc_gen_en)   crc_reg <= crc_bit(crc_reg, crc_din);
        else if (crc_out_en)   crc_reg <= {crc_reg[14:0], 1'b0};
    end

    // Byte source
    logic [7:0] src [8];
    int src_idx = 0, drop_cnt = 0;
    bit gaps = 1'b0;

    // Reference model: position in the bit stream of the current block
    bit          m_act = 1'b0, m_multi = 1'b0, m_done = 1'b0, m_ur = 1'b0, m_last = 1'b1;
    int          m_k = 0;
    logic [7:0]  m_cur = 8'h00, m_tok;
    logic [15:0] m_crc = 16'h0000;
    int          j, bi, bp;
    bit          stl, exp_br, eb;
    logic        rx [NBITS];
    int          gen_cnt = 0, out_cnt = 0, lds_cnt = 0, ldm_cnt = 0, br_cnt = 0, n_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_act = 1'b0; m_done = 1'b0; m_ur = 1'b0; m_last = 1'b1;
        end else begin
            gen_cnt += int'(crc_gen_en); out_cnt += int'(crc_out_en);
            lds_cnt += int'(crc_ld_start); ldm_cnt += int'(crc_ld_multi);
            br_cnt  += int'(byte_ready); n_done += int'(done);
            if (byte_ready) src_idx++;
            check("busy", busy, m_act);
            check("done", done, m_done);
            check("underrun", underrun, m_ur);
            m_done = 1'b0;
            if (!bit_en || !m_act) begin
                check("gen_idle", crc_gen_en, 0);
                check("out_idle", crc_out_en, 0);
                check("lds_idle", crc_ld_start, 0);
                check("ldm_idle", crc_ld_multi, 0);
                check("br_idle", byte_ready, 0);
                if (!m_act) check("sdo_idle", sdo, 1);
                if (!m_act && start) begin
                    m_act = 1'b1; m_k = 0; m_multi = multi_blk; m_ur = 1'b0;
                    m_crc = multi_blk ? SEED_M : SEED_S;
                    gen_cnt = 0; out_cnt = 0; lds_cnt = 0; ldm_cnt = 0; br_cnt = 0; n_done = 0;
                end
            end else if (m_k < 8) begin
                m_tok = m_multi ? 8'hFC : 8'hFE;
                eb = m_tok[7 - m_k];
                check("tok_sdo", sdo, eb);
                check("tok_gen", crc_gen_en, 0);
                check("tok_out", crc_out_en, 0);
                check("tok_br", byte_ready, 0);
                check("tok_lds", crc_ld_start, (m_k == 7) && !m_multi);
                check("tok_ldm", crc_ld_multi, (m_k == 7) && m_multi);
                rx[m_k] = sdo; m_last = eb; m_k++;
            end else if (m_k < 8 + DBITS) begin
                j = m_k - 8; bi = j / 8; bp = j % 8; stl = 1'b0; exp_br = 1'b0;
                if (bp == 0) begin
                    if (byte_valid) begin
                        m_cur = byte_data; exp_br = 1'b1;
                    end else begin
`ifdef SPI_BLK_TX_UNDERRUN_EN
                        m_cur = 8'hFF; m_ur = 1'b1;
`else
                        stl = 1'b1;
`endif
                    end
                end
                check("dat_out", crc_out_en, 0);
                check("dat_lds", crc_ld_start, 0);
                check("dat_ldm", crc_ld_multi, 0);
                check("dat_br", byte_ready, exp_br);
                if (stl) begin
                    check("stall_sdo", sdo, m_last);
                    check("stall_gen", crc_gen_en, 0);
                end else begin
                    eb = m_cur[7 - bp];
                    check("dat_sdo", sdo, eb);
                    check("dat_din", crc_din, eb);
                    check("dat_gen", crc_gen_en, 1);
                    if (bp == 7) m_crc = crc_byte(m_crc, m_cur);
                    rx[m_k] = sdo; m_last = eb; m_k++;
                end
            end else begin
                eb = m_crc[15 - (m_k - 8 - DBITS)];
                check("crc_sdo", sdo, eb);
                check("crc_out", crc_out_en, 1);
                check("crc_gen", crc_gen_en, 0);
                check("crc_br", byte_ready, 0);
                check("crc_ld", {crc_ld_start, crc_ld_multi}, 0);
                rx[m_k] = sdo; m_k++;
                if (m_k == NBITS) begin m_act = 1'b0; m_done = 1'b1; end
            end
        end
    end

    function automatic logic [7:0] rx_byte(input int i);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[7 - b] = rx[8 * i + b];
        return r;
    endfunction

    function automatic logic [15:0] rx_crc();
        logic [15:0] r;
        for (int b = 0; b < 16; b++) r[15 - b] = rx[8 + DBITS + b];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
        bit_en = ~bit_en;
        if (drop_cnt > 0) drop_cnt--;
        byte_valid = (drop_cnt == 0) && !(gaps && $urandom_range(0, 3) == 0);
        byte_data  = src[src_idx % 8];
    endtask

    task automatic launch(input logic m, input logic align);
        while (bit_en !== align) tick();
        start = 1'b1; multi_blk = m; src_idx = 0; byte_data = src[0];
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (n_done == 0 && t < 1000) begin tick(); t++; end
        tick();
        check("done_once", n_done, 1);
    endtask

    task automatic wait_br(input int n);
        int t;
        t = 0;
        while (br_cnt < n && t < 200) begin tick(); t++; end
        check("br_reached", br_cnt >= n, 1);
    endtask

    task automatic lit_block(input logic m, input logic [7:0] b0, b1, b2, b3, input int nbr);
        logic [15:0] c;
        c = m ? SEED_M : SEED_S;
        c = crc_byte(crc_byte(crc_byte(crc_byte(c, b0), b1), b2), b3);
        check("lit_token", rx_byte(0), m ? 8'hFC : 8'hFE);
        check("lit_b0", rx_byte(1), b0);
        check("lit_b1", rx_byte(2), b1);
        check("lit_b2", rx_byte(3), b2);
        check("lit_b3", rx_byte(4), b3);
        check("lit_crc", rx_crc(), c);
        check("lit_ngen", gen_cnt, 32);
        check("lit_nout", out_cnt, 16);
        check("lit_nlds", lds_cnt, m ? 0 : 1);
        check("lit_nldm", ldm_cnt, m ? 1 : 0);
        check("lit_nbr", br_cnt, nbr);
    endtask

    task automatic set_src(input logic [7:0] a, b, c, d);
        src[0] = a; src[1] = b; src[2] = c; src[3] = d;
        for (int i = 4; i < 8; i++) src[i] = 8'h5A;
    endtask

    logic [7:0] ascii [9];
    logic [15:0] pin;

    initial begin
        set_src(8'hA5, 8'h3C, 8'h00, 8'hFF);
        // Pin the CRC function: CRC16-CCITT zero-init of "123456789" is 0x31C3.
        for (int i = 0; i < 9; i++) ascii[i] = 8'h31 + 8'(i);
        pin = 16'h0000;
        for (int i = 0; i < 9; i++) pin = crc_byte(pin, ascii[i]);
        check("pin_crc", pin, 16'h31C3);
        pin = crc_byte(16'h0000, 8'hFE);
        check("pin_seed", pin, SEED_S);

        repeat (4) tick();
        rst_n = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_sdo", sdo, 1);
        check("rst_done", done, 0);
        check("rst_ur", underrun, 0);
        check("rst_br", byte_ready, 0);
        repeat (3) tick();

        // 1: single block, always valid
        launch(1'b0, 1'b0);
        wait_done();
        lit_block(1'b0, 8'hA5, 8'h3C, 8'h00, 8'hFF, 4);

        // 2: multi block token
        launch(1'b1, 1'b0);
        wait_done();
        lit_block(1'b1, 8'hA5, 8'h3C, 8'h00, 8'hFF, 4);

        // 3: byte_valid held low around the third byte fetch
        set_src(8'h11, 8'h22, 8'h33, 8'h44);
        launch(1'b0, 1'b0);
        wait_br(2);
        repeat (12) tick();
        drop_cnt = 11;
        wait_done();
`ifdef SPI_BLK_TX_UNDERRUN_EN
        lit_block(1'b0, 8'h11, 8'h22, 8'hFF, 8'h33, 3);
        check("ur_sticky", underrun, 1);
        launch(1'b0, 1'b0);
        tick();
        check("ur_cleared", underrun, 0);
        wait_done();
`else
        lit_block(1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 4);
        check("ur_tied", underrun, 0);
`endif

        // 4: reset mid-DATA, then a clean block
        set_src(8'hA5, 8'h3C, 8'h00, 8'hFF);
        launch(1'b1, 1'b0);
        wait_br(2);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sdo", sdo, 1);
        repeat (6) tick();
        check("mid_rst_nodone", n_done, 0);
        launch(1'b0, 1'b0);
        wait_done();
        lit_block(1'b0, 8'hA5, 8'h3C, 8'h00, 8'hFF, 4);

        // 5: start coincident with bit_en in IDLE; start while busy is ignored
        launch(1'b0, 1'b1);
        repeat (20) tick();
        start = 1'b1; multi_blk = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        lit_block(1'b0, 8'hA5, 8'h3C, 8'h00, 8'hFF, 4);

        // Randomised blocks with sporadic byte_valid gaps
        gaps = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 8; i++) src[i] = 8'($urandom);
            launch(1'($urandom), 1'($urandom));
            wait_done();
            repeat ($urandom_range(0, 5)) tick();
        end
        gaps = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
